// File: rtl/audio_pkg.sv
// Shared types and sample-extraction helper for the per-channel audio line cache.
package audio_pkg;

    typedef enum logic {
        SAMPLE_8  = 1'b0,
        SAMPLE_16 = 1'b1
    } sample_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FILL   = 2'd2,
        REPLAY = 2'd3
    } linecache_state_t;

    // 8-bit samples are replicated into both halves; 16-bit samples are little-endian halfwords.
    function automatic logic [15:0] sample_extract(input logic [31:0] word,
                                                   input logic [1:0] lo,
                                                   input sample_mode_t mode);
        logic [7:0] b;
        b = word[8*lo +: 8];
        if (mode == SAMPLE_16) begin
            return lo[1] ? word[31:16] : word[15:0];
        end
        return {b, b};
    endfunction

endpackage

// File: rtl/audio_linecache_ram.sv
// Line storage for all channels: one write port, one registered read port.
module audio_linecache_ram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/audio_linecache.sv
// Per-channel single-line read cache for audio samples, refilled by SDRAM burst reads.
module audio_linecache
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned LINE_WORDS   = 16,
    parameter int unsigned ADDR_WIDTH   = 26,
    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [CH_W-1:0]       req_channel,
    input  logic                  req_mode,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [15:0]           resp_data,
    input  logic                  flush,
    input  logic [CH_W-1:0]       flush_channel,
    output logic                  sdram_request,
    output logic [ADDR_WIDTH-1:0] sdram_address,
    input  logic                  sdram_ready,
    input  logic                  sdram_rvalid,
    input  logic [ADDR_WIDTH-1:0] sdram_raddress,
    input  logic [31:0]           sdram_rdata,
    input  logic                  sdram_complete
);

    localparam int unsigned OFF_W  = $clog2(4 * LINE_WORDS);
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W;
    localparam int unsigned RAM_AW = CH_W + WORD_W;

    linecache_state_t state_q, state_d;

    logic [NUM_CHANNELS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]   lat_addr_q;
    logic [CH_W-1:0]         lat_ch_q;
    sample_mode_t            lat_mode_q;
    logic                    killed_q;
    logic                    sdram_request_q;
    logic [ADDR_WIDTH-1:0]   sdram_address_q;
    logic                    resp_pend_q, resp_pend_d;
    logic [1:0]              sel_lo_q;
    sample_mode_t            sel_mode_q;

    logic              hit, fill_match, miss_start, fill_done, ram_wr_en;
    logic [RAM_AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [31:0]       ram_rd_data;
    logic              unused_bits;

    assign hit = valid_q[req_channel] && (tag_q[req_channel] == req_addr[ADDR_WIDTH-1:OFF_W]);
    assign fill_match = sdram_rvalid &&
                        (sdram_raddress[ADDR_WIDTH-1:OFF_W] == lat_addr_q[ADDR_WIDTH-1:OFF_W]);
    assign ram_wr_addr = {lat_ch_q, sdram_raddress[OFF_W-1:2]};
    assign unused_bits = ^sdram_raddress[1:0];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_start  = 1'b0;
        fill_done   = 1'b0;
        resp_pend_d = 1'b0;
        ram_wr_en   = 1'b0;
        ram_rd_addr = {req_channel, req_addr[OFF_W-1:2]};
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        resp_pend_d = 1'b1;
                    end else begin
                        miss_start           = 1'b1;
                        valid_d[req_channel] = 1'b0;
                        state_d              = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (sdram_ready) state_d = FILL;
            end
            FILL: begin
                ram_wr_en = fill_match;
                if (sdram_complete) begin
                    fill_done = 1'b1;
                    state_d   = REPLAY;
                end
            end
            REPLAY: begin
                ram_rd_addr = {lat_ch_q, lat_addr_q[OFF_W-1:2]};
                resp_pend_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) valid_d[flush_channel] = 1'b0;
        // A flush that hit the line being refilled keeps it invalid after the burst lands.
        if (fill_done) valid_d[lat_ch_q] = !(killed_q || (flush && flush_channel == lat_ch_q));
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q         <= '0;
            sdram_request_q <= 1'b0;
            sdram_address_q <= '0;
            resp_pend_q     <= 1'b0;
            killed_q        <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            resp_pend_q <= resp_pend_d;
            if (miss_start) begin
                sdram_request_q <= 1'b1;
                sdram_address_q <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                killed_q        <= flush && (flush_channel == req_channel);
            end else if (state_q == ISSUE && sdram_ready) begin
                sdram_request_q <= 1'b0;
            end
            if (flush && flush_channel == lat_ch_q && (state_q == ISSUE || state_q == FILL)) begin
                killed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (miss_start) begin
            lat_addr_q <= req_addr;
            lat_ch_q   <= req_channel;
            lat_mode_q <= sample_mode_t'(req_mode);
        end
        if (fill_done) tag_q[lat_ch_q] <= lat_addr_q[ADDR_WIDTH-1:OFF_W];
        if (resp_pend_d) begin
            sel_lo_q   <= (state_q == REPLAY) ? lat_addr_q[1:0] : req_addr[1:0];
            sel_mode_q <= (state_q == REPLAY) ? lat_mode_q : sample_mode_t'(req_mode);
        end
    end

    audio_linecache_ram #(
        .DEPTH(NUM_CHANNELS * LINE_WORDS),
        .AW   (RAM_AW),
        .DW   (32)
    ) u_ram (
        .clock  (clock),
        .wr_en  (ram_wr_en),
        .wr_addr(ram_wr_addr),
        .wr_data(sdram_rdata),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_rd_data)
    );

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = resp_pend_q;
    assign resp_data     = resp_pend_q ? sample_extract(ram_rd_data, sel_lo_q, sel_mode_q) : 16'h0;
    assign sdram_request = sdram_request_q;
    assign sdram_address = sdram_address_q;

endmodule

// File: tb/tb_audio_linecache.sv
// Directed self-checking bench for audio_linecache with default parameters.
module tb_audio_linecache;

    localparam int unsigned AW = 26;

    logic          clock = 1'b0;
    logic          reset;
    logic          req;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_channel;
    logic          req_mode;
    logic          req_ready;
    logic          resp_valid;
    logic [15:0]   resp_data;
    logic          flush;
    logic [2:0]    flush_channel;
    logic          sdram_request;
    logic [AW-1:0] sdram_address;
    logic          sdram_ready;
    logic          sdram_rvalid;
    logic [AW-1:0] sdram_raddress;
    logic [31:0]   sdram_rdata;
    logic          sdram_complete;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] hit8_addr  [4] = '{26'h1235, 26'h1236, 26'h1237, 26'h1238};
    logic [15:0]   hit8_exp   [4] = '{16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h1E1E};
    logic [AW-1:0] hit16_addr [3] = '{26'h1236, 26'h1234, 26'h1237};
    logic [15:0]   hit16_exp  [3] = '{16'hAABB, 16'hCCDD, 16'hAABB};

    always #5 clock = ~clock;

    audio_linecache dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_addr      (req_addr),
        .req_channel   (req_channel),
        .req_mode      (req_mode),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .flush         (flush),
        .flush_channel (flush_channel),
        .sdram_request (sdram_request),
        .sdram_address (sdram_address),
        .sdram_ready   (sdram_ready),
        .sdram_rvalid  (sdram_rvalid),
        .sdram_raddress(sdram_raddress),
        .sdram_rdata   (sdram_rdata),
        .sdram_complete(sdram_complete)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
        sdram_rvalid   = 1'b1;
        sdram_raddress = a;
        sdram_rdata    = d;
        sdram_complete = last;
        tick();
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b0;
    endtask

    function automatic logic [31:0] fw(input int i);
        if (i == 13) return 32'hAABBCCDD;
        return {8'(32'h40 + i), 8'(32'h30 + i), 8'(32'h20 + i), 8'(32'h10 + i)};
    endfunction

    initial begin
        reset = 1'b0; req = 1'b0; req_addr = '0; req_channel = '0; req_mode = 1'b0;
        flush = 1'b0; flush_channel = '0; sdram_ready = 1'b0; sdram_rvalid = 1'b0;
        sdram_raddress = '0; sdram_rdata = '0; sdram_complete = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 1);
        check("rst_sdram_req", 32'(sdram_request), 0);
        check("rst_sdram_addr", 32'(sdram_address), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        reset = 1'b1;

        // Cold miss on channel 3
        req = 1'b1; req_addr = 26'h1234; req_channel = 3'd3; req_mode = 1'b0;
        tick();
        req = 1'b0;
        check("miss_req", 32'(sdram_request), 1);
        check("miss_addr", 32'(sdram_address), 32'h1200);
        check("miss_busy", 32'(req_ready), 0);
        tick();
        check("issue_hold", 32'(sdram_request), 1);
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        check("issue_drop", 32'(sdram_request), 0);

        // Channel 5 request held during the fill must not steer the writes
        req = 1'b1; req_channel = 3'd5; req_addr = 26'h1234;
        for (int i = 0; i < 13; i++) begin
            send_word(26'h1200 + 26'(4 * i), fw(i), 1'b0);
        end
        check("fill_busy", 32'(req_ready), 0);
        req = 1'b0;
        send_word(26'h1238, fw(14), 1'b0);
        send_word(26'h123C, fw(15), 1'b0);
        send_word(26'h1634, 32'hDEADBEEF, 1'b0);
        send_word(26'h1234, fw(13), 1'b1);
        check("cold_lat1", 32'(resp_valid), 0);
        tick();
        check("cold_valid", 32'(resp_valid), 1);
        check("cold_data", 32'(resp_data), 32'hDDDD);
        tick();
        check("cold_idle_valid", 32'(resp_valid), 0);
        check("cold_idle_data", 32'(resp_data), 0);
        check("cold_ready", 32'(req_ready), 1);

        // Back-to-back 8-bit hits
        req = 1'b1; req_channel = 3'd3; req_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = hit8_addr[i];
            check("hit8_ready", 32'(req_ready), 1);
            tick();
            check("hit8_valid", 32'(resp_valid), 1);
            check("hit8_data", 32'(resp_data), 32'(hit8_exp[i]));
            check("hit8_nosdram", 32'(sdram_request), 0);
        end
        req_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = hit16_addr[i];
            tick();
            check("hit16_valid", 32'(resp_valid), 1);
            check("hit16_data", 32'(resp_data), 32'(hit16_exp[i]));
        end
        req = 1'b0; req_mode = 1'b0;
        tick();
        check("hit_end", 32'(resp_valid), 0);

        // Channel 5 stayed invalid; give it its own line
        req = 1'b1; req_channel = 3'd5; req_addr = 26'h1234;
        tick();
        req = 1'b0;
        check("ch5_miss", 32'(sdram_request), 1);
        check("ch5_addr", 32'(sdram_address), 32'h1200);
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        send_word(26'h1234, 32'h55667788, 1'b1);
        tick();
        check("ch5_valid", 32'(resp_valid), 1);
        check("ch5_data", 32'(resp_data), 32'h8888);
        tick();
        req = 1'b1; req_channel = 3'd3; req_addr = 26'h1234;
        tick();
        req = 1'b0;
        check("ch3_keep_valid", 32'(resp_valid), 1);
        check("ch3_keep_data", 32'(resp_data), 32'hDDDD);
        check("ch3_keep_nomiss", 32'(sdram_request), 0);
        tick();

        // Flush of channel 3 during its fill
        req = 1'b1; req_channel = 3'd3; req_addr = 26'h2000;
        tick();
        req = 1'b0;
        check("fl_miss_addr", 32'(sdram_address), 32'h2000);
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        flush = 1'b1; flush_channel = 3'd3;
        send_word(26'h2004, 32'h00000011, 1'b0);
        flush = 1'b0;
        send_word(26'h2000, 32'h000000EE, 1'b1);
        tick();
        check("fl_resp_valid", 32'(resp_valid), 1);
        check("fl_resp_data", 32'(resp_data), 32'hEEEE);
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("fl_remiss", 32'(sdram_request), 1);
        check("fl_remiss_valid", 32'(resp_valid), 0);
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        send_word(26'h2000, 32'h12345678, 1'b1);
        tick();
        check("refill_data", 32'(resp_data), 32'h7878);
        tick();

        // Flush in the same cycle as a hit: old data served, next request misses
        req = 1'b1; flush = 1'b1; flush_channel = 3'd3;
        tick();
        req = 1'b0; flush = 1'b0;
        check("flhit_valid", 32'(resp_valid), 1);
        check("flhit_data", 32'(resp_data), 32'h7878);
        check("flhit_nomiss", 32'(sdram_request), 0);
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("flhit_later_miss", 32'(sdram_request), 1);
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        send_word(26'h2000, 32'h12345678, 1'b1);
        tick();
        tick();

        // Reset in the middle of a channel 6 fill, then stray returns
        req = 1'b1; req_channel = 3'd6; req_addr = 26'h3000;
        tick();
        req = 1'b0;
        sdram_ready = 1'b1;
        tick();
        sdram_ready = 1'b0;
        send_word(26'h3000, 32'h99999999, 1'b0);
        reset = 1'b0;
        tick();
        check("rst2_ready", 32'(req_ready), 1);
        check("rst2_sdram_req", 32'(sdram_request), 0);
        check("rst2_sdram_addr", 32'(sdram_address), 0);
        check("rst2_resp_valid", 32'(resp_valid), 0);
        reset = 1'b1;
        send_word(26'h3004, 32'h00000001, 1'b0);
        send_word(26'h3000, 32'h00000002, 1'b1);
        check("stray_none", 32'(resp_valid), 0);
        tick();
        check("stray_none2", 32'(resp_valid), 0);
        check("stray_ready", 32'(req_ready), 1);
        req = 1'b1; req_channel = 3'd3; req_addr = 26'h2000;
        tick();
        req = 1'b0;
        check("post_rst_miss", 32'(sdram_request), 1);
        check("post_rst_noresp", 32'(resp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_linecache.md
AUDIO_LINECACHE -- requirements
Module: audio_linecache

Interface
REQ-001 Parameter NUM_CHANNELS, default 8: number of audio channels, each owning one private cache line (power of two, 1..16).
REQ-002 Parameter LINE_WORDS, default 16: 32-bit words per line (power of two, 4..64); LINE_BYTES = 4*LINE_WORDS.
REQ-003 Parameter ADDR_WIDTH, default 26: byte-address width.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req  input  1  read request; req_addr, req_channel and req_mode are valid while high.
REQ-007 req_addr  input  ADDR_WIDTH  sample byte address.
REQ-008 req_channel  input  $clog2(NUM_CHANNELS)  requesting channel.
REQ-009 req_mode  input  1  0 = 8-bit sample, 1 = 16-bit sample.
REQ-010 req_ready  output  1  request accepted when req && req_ready.
REQ-011 resp_valid  output  1  one-cycle pulse; resp_data valid.
REQ-012 resp_data  output  16  sample.
REQ-013 flush  input  1  invalidate line of flush_channel this cycle.
REQ-014 flush_channel  input  $clog2(NUM_CHANNELS)  channel to invalidate.
REQ-015 sdram_request/sdram_address  output  1/ADDR_WIDTH  burst-read request, line-aligned address.
REQ-016 sdram_ready, sdram_rvalid, sdram_raddress[ADDR_WIDTH], sdram_rdata[32], sdram_complete  inputs  SDRAM burst-read return path.

Function
REQ-017 Per channel: tag (ADDR_WIDTH-log2(LINE_BYTES) bits) plus valid bit; hit = valid && tag == req_addr line bits.
REQ-018 FSM states IDLE, ISSUE, FILL, REPLAY; req_ready = 1 only in IDLE.
REQ-019 IDLE, accept, hit: stay IDLE; data RAM read issued; resp_valid exactly 1 cycle after accept; back-to-back hits every cycle.
REQ-020 IDLE, accept, miss: latch addr/channel/mode; clear that channel's valid; go ISSUE with sdram_request=1, sdram_address = req_addr with low log2(LINE_BYTES) bits zeroed.
REQ-021 ISSUE: sdram_request held until sampled with sdram_ready=1, then drops next cycle; go FILL.
REQ-022 FILL: each sdram_rvalid whose raddress line bits match the latched line writes sdram_rdata to word raddress[log2(LINE_BYTES)-1:2] of the latched channel (never req_channel); non-matching or out-of-FILL rvalid ignored.
REQ-023 FILL, sdram_complete: write latched tag, set valid (unless flushed during fill), go REPLAY.
REQ-024 REPLAY: read latched word; resp_valid next cycle; return IDLE; miss latency = sdram_complete + 2 cycles.
REQ-025 8-bit mode: byte addr[1:0] replicated, resp_data = {b,b}; 16-bit mode: halfword addr[1] (addr[0] ignored), little-endian.
REQ-026 resp_data = 0 when resp_valid = 0.
REQ-027 flush clears valid immediately; flush same cycle as hit-accept on same channel: current response still served from old data, later requests miss.
REQ-028 flush of latched channel during ISSUE/FILL: burst completes, pending request answered, valid left 0.
REQ-029 Simultaneous sdram_rvalid and sdram_complete: word written before tag/valid update.

Reset
REQ-030 reset=0 at edge: state IDLE, all valid=0, sdram_request=0, sdram_address=0, resp_valid=0, req_ready=1 next cycle; a fill in progress is abandoned and its late returns ignored (state not FILL).

Structure
REQ-031 Package audio_pkg holds sample_mode_t enum (SAMPLE_8, SAMPLE_16) and linecache_state_t enum.
REQ-032 Sub-module audio_linecache_ram: NUM_CHANNELS*LINE_WORDS x 32 simple dual-port, one write, one registered read port.

Verification
REQ-033 Cold request ch3 addr 0x001234 8-bit -> sdram_address 0x001200, after burst/complete resp_valid 2 cycles later, resp_data {byte 0x34 of line, same}.
REQ-034 Subsequent ch3 requests 0x001235..0x001238 back-to-back -> four hits, resp_valid 1 cycle after each, no sdram_request.
REQ-035 16-bit mode addr 0x001236 word 0xAABBCCDD -> resp_data 0xAABB; addr 0x001234 -> 0xCCDD.
REQ-036 req_channel changes to 5 during ch3 fill -> data lands in ch3 line only; ch5 stays invalid.
REQ-037 flush ch3 mid-FILL -> pending response delivered, next ch3 request to same line misses.
REQ-038 reset low mid-FILL, then stray rvalid/complete -> no RAM/tag update; first later request misses.
